// File: rtl/prog_feeder.sv
// prog_feeder: instruction sequencer in front of the 9-bit bus processor.
// Fetches program words from a synchronous-read memory, issues each one on
// DIN with a single-cycle Run pulse, supplies the mvi immediate on the next
// cycle, and waits for Done before fetching again. Opcodes 100-111 halt.
//
// Ports
//   Clock    rising-edge clock
//   Reset    asynchronous, active-high reset
//   Start    begin execution at address 0 (IDLE or HALTED only)
//   Done     processor Done (combinational from the processor)
//   MemData  program memory read data, valid the cycle after MemAddr
//   MemAddr  program memory address (combinational)
//   DIN      processor DIN (combinational, zero outside ISSUE/IMM)
//   Run      processor Run, high only in the ISSUE cycle of a real opcode
//   PC       address of the current instruction
//   Busy     high in FETCH, ISSUE, IMM and WAIT
//   Halted   HALT opcode reached
//   Error    sticky Done timeout flag; only Reset clears it
module prog_feeder #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned TIMEOUT = 3
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Done,
  input  logic [8:0]        MemData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [8:0]        DIN,
  output logic              Run,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  output logic              Halted,
  output logic              Error
);

  // Counts Done-less IMM/WAIT cycles from 0 up to TIMEOUT-1.
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [2:0] OP_MVI = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_IMM,
    S_WAIT,
    S_HALTED,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              run_q;
  logic              busy_q;
  logic              halted_q;
  logic              error_q;

  logic [2:0]        opcode;
  logic              halt_op;
  logic              timed_out;

  assign opcode    = MemData[8:6];
  assign halt_op   = MemData[8];
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

  // State, PC, timeout counter and registered status flags.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      run_q    <= (state_d == S_ISSUE);
      busy_q   <= (state_d == S_FETCH) || (state_d == S_ISSUE) ||
                  (state_d == S_IMM)   || (state_d == S_WAIT);
      halted_q <= (state_d == S_HALTED);
      error_q  <= (state_d == S_ERROR);
    end
  end

  // Next-state, PC and timeout counter.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (Start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_ISSUE;
      S_ISSUE: begin
        cnt_d = '0;
        if (halt_op)               state_d = S_HALTED;
        else if (opcode == OP_MVI) state_d = S_IMM;
        else                       state_d = S_WAIT;
      end
      S_IMM, S_WAIT: begin
        if (Done) begin
          pc_d    = (state_q == S_IMM) ? pc_q + ADDR_W'(2) : pc_q + ADDR_W'(1);
          state_d = S_FETCH;
        end else if (timed_out) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  // The opcode only arrives during ISSUE, so a HALT masks the registered pulse.
  assign Run     = run_q & ~halt_op;
  // In ISSUE the memory is already reading the mvi immediate at PC+1.
  assign MemAddr = (state_q == S_ISSUE) ? pc_q + ADDR_W'(1) : pc_q;
  assign DIN     = ((state_q == S_ISSUE) || (state_q == S_IMM)) ? MemData : 9'b0;
  assign PC      = pc_q;
  assign Busy    = busy_q;
  assign Halted  = halted_q;
  assign Error   = error_q;

endmodule

// File: tb/tb_prog_feeder.sv
// Directed bench for prog_feeder with a behavioural bus-processor model.
module tb_prog_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start2;
  logic       done, done2;
  logic [8:0] mem_data, mem_data2;
  logic [4:0] mem_addr, pc;
  logic [1:0] mem_addr2, pc2;
  logic [8:0] din, din2;
  logic       run, busy, halted, error;
  logic       run2, busy2, halted2, error2;

  int checks = 0;
  int fails  = 0;

  logic [8:0] mem  [0:31];
  logic [8:0] mem2 [0:3];

  // processor model state
  logic [1:0] t;
  logic [8:0] ir, a, g;
  logic [8:0] r [0:7];
  logic       proc_hang, done_force;

  always #5 clk = ~clk;

  prog_feeder #(.ADDR_W(5), .TIMEOUT(3)) dut (
    .Clock(clk), .Reset(rst), .Start(start), .Done(done), .MemData(mem_data),
    .MemAddr(mem_addr), .DIN(din), .Run(run), .PC(pc), .Busy(busy),
    .Halted(halted), .Error(error)
  );

  prog_feeder #(.ADDR_W(2), .TIMEOUT(3)) dut2 (
    .Clock(clk), .Reset(rst), .Start(start2), .Done(done2), .MemData(mem_data2),
    .MemAddr(mem_addr2), .DIN(din2), .Run(run2), .PC(pc2), .Busy(busy2),
    .Halted(halted2), .Error(error2)
  );

  always @(posedge clk) mem_data  <= mem[mem_addr];
  always @(posedge clk) mem_data2 <= mem2[mem_addr2];
  assign done2 = 1'b1;

  // Done: T1 for mv/mvi, T3 for add/sub.
  assign done = done_force | (!proc_hang &&
                ((t == 2'd1 && ir[8:6] <= 3'd1) || (t == 2'd3 && ir[8:7] == 2'b01)));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t  <= 2'd0;
      ir <= 9'd0;
      a  <= 9'd0;
      g  <= 9'd0;
      for (int i = 0; i < 8; i++) r[i] <= 9'd0;
    end else begin
      case (t)
        2'd0: if (run) begin ir <= din; t <= 2'd1; end
        2'd1: begin
          case (ir[8:6])
            3'd0:    begin r[ir[5:3]] <= r[ir[2:0]]; t <= 2'd0; end
            3'd1:    begin r[ir[5:3]] <= din;        t <= 2'd0; end
            default: begin a <= r[ir[5:3]];          t <= 2'd2; end
          endcase
        end
        2'd2: begin
          g <= (ir[8:6] == 3'd2) ? a + r[ir[2:0]] : a - r[ir[2:0]];
          t <= 2'd3;
        end
        default: begin r[ir[5:3]] <= g; t <= 2'd0; end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; start2 = 1'b0; done_force = 1'b0; proc_hang = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 9'h100;
    for (int i = 0; i < 4; i++) mem2[i] = 9'h100;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({run, din, mem_addr, pc, busy, halted, error} !== 23'd0) begin
      fails++;
      $display("FAIL reset_outputs: run=%b din=%h addr=%0d pc=%0d busy=%b halted=%b error=%b, want all 0",
               run, din, mem_addr, pc, busy, halted, error);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mvi();
    int run_cnt = 0;
    do_reset();
    mem[0] = 9'b001000000; mem[1] = 9'd5; mem[2] = 9'b100000000;
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      start = 1'b0;
      if (run) run_cnt++;
      if (c == 2) begin
        checks++;
        if (run !== 1'b1 || din !== 9'b001000000) begin
          fails++; $display("FAIL mvi_issue: run=%b din=%b, want 1 001000000", run, din);
        end
      end
      if (c == 3) begin
        checks++;
        if (din !== 9'd5) begin fails++; $display("FAIL mvi_imm: din=%0d, want 5", din); end
      end
      if (c == 4) begin
        checks++;
        if (pc !== 5'd2) begin fails++; $display("FAIL mvi_pc: pc=%0d, want 2", pc); end
      end
      if (c == 5) begin
        checks++;
        if (halted !== 1'b0 || run !== 1'b0 || busy !== 1'b1) begin
          fails++; $display("FAIL halt_issue: halted=%b run=%b busy=%b, want 0 0 1", halted, run, busy);
        end
      end
      if (c == 7) begin
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0) begin
          fails++; $display("FAIL halted_flag: halted=%b busy=%b, want 1 0", halted, busy);
        end
      end
    end
    checks++;
    if (run_cnt !== 1) begin fails++; $display("FAIL mvi_run_count: got %0d, want 1", run_cnt); end
    checks++;
    if (r[0] !== 9'd5) begin fails++; $display("FAIL mvi_r0: got %0d, want 5", r[0]); end
  endtask

  task automatic test_add_sub();
    int t4 = -1, t5 = -1, t6 = -1;
    do_reset();
    mem[0] = 9'b001001000; mem[1] = 9'd3;
    mem[2] = 9'b001010000; mem[3] = 9'd4;
    mem[4] = 9'b010001010; mem[5] = 9'b011001010;
    mem[6] = 9'b100000000;
    start = 1'b1;
    for (int c = 1; c <= 40 && !halted; c++) begin
      tick();
      start = 1'b0;
      if (pc == 5'd4 && t4 < 0) t4 = c;
      if (pc == 5'd5 && t5 < 0) begin
        t5 = c;
        checks++;
        if (r[1] !== 9'd7) begin fails++; $display("FAIL add_result: r1=%0d, want 7", r[1]); end
      end
      if (pc == 5'd6 && t6 < 0) begin
        t6 = c;
        checks++;
        if (r[1] !== 9'd3) begin fails++; $display("FAIL sub_result: r1=%0d, want 3", r[1]); end
      end
    end
    checks++;
    if (halted !== 1'b1) begin fails++; $display("FAIL addsub_halt: halted=%b, want 1", halted); end
    checks++;
    if (t4 !== 7 || t5 !== 12 || t6 !== 17) begin
      fails++; $display("FAIL addsub_timing: fetch at %0d/%0d/%0d, want 7/12/17", t4, t5, t6);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    mem2[0] = 9'd9;          // executes as mv R1,R1, then serves as the wrapped immediate
    mem2[1] = 9'b001001000;
    mem2[2] = 9'd7;
    mem2[3] = 9'b001000000;
    start2 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start2 = 1'b0;
      if (c == 8) begin
        checks++;
        if (run2 !== 1'b1 || din2 !== 9'b001000000 || pc2 !== 2'd3 || mem_addr2 !== 2'd0) begin
          fails++; $display("FAIL wrap_issue: run=%b din=%b pc=%0d addr=%0d, want 1 001000000 3 0",
                            run2, din2, pc2, mem_addr2);
        end
      end
      if (c == 9) begin
        checks++;
        if (din2 !== 9'd9) begin fails++; $display("FAIL wrap_imm: din=%0d, want 9", din2); end
      end
      if (c == 10) begin
        checks++;
        if (pc2 !== 2'd1) begin fails++; $display("FAIL wrap_pc: pc=%0d, want 1", pc2); end
      end
    end
  endtask

  task automatic test_timeout();
    int run_cnt = 0;
    do_reset();
    mem[0] = 9'b010001010;
    proc_hang = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      start = 1'b0;
      if (c >= 3 && run) run_cnt++;
      if (c == 5) begin
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
          fails++; $display("FAIL timeout_early: error=%b busy=%b, want 0 1", error, busy);
        end
      end
    end
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || run_cnt !== 0) begin
      fails++; $display("FAIL timeout_error: error=%b busy=%b runs=%0d, want 1 0 0", error, busy, run_cnt);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || run !== 1'b0) begin
      fails++; $display("FAIL timeout_sticky: error=%b busy=%b run=%b, want 1 0 0", error, busy, run);
    end
    do_reset();
    checks++;
    if (error !== 1'b0) begin fails++; $display("FAIL timeout_clear: error=%b, want 0", error); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem[0] = 9'b000011011; mem[1] = 9'b010001010; mem[2] = 9'b100000000;
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      start = 1'b0;
    end
    checks++;
    if (pc !== 5'd1 || busy !== 1'b1) begin
      fails++; $display("FAIL midreset_pre: pc=%0d busy=%b, want 1 1", pc, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (run !== 1'b0 || din !== 9'd0 || pc !== 5'd0 || busy !== 1'b0 || mem_addr !== 5'd0) begin
      fails++; $display("FAIL midreset_async: run=%b din=%h pc=%0d busy=%b addr=%0d, want 0",
                        run, din, pc, busy, mem_addr);
    end
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || pc !== 5'd0 || mem_addr !== 5'd0) begin
      fails++; $display("FAIL midreset_refetch: busy=%b pc=%0d addr=%0d, want 1 0 0", busy, pc, mem_addr);
    end
    tick();
    checks++;
    if (run !== 1'b1 || din !== 9'b000011011) begin
      fails++; $display("FAIL midreset_issue: run=%b din=%b, want 1 000011011", run, din);
    end
  endtask

  task automatic test_ignored();
    do_reset();
    done_force = 1'b1;
    tick();
    tick();
    done_force = 1'b0;
    checks++;
    if ({busy, halted, run, pc} !== 8'd0) begin
      fails++; $display("FAIL done_in_idle: busy=%b halted=%b run=%b pc=%0d, want 0", busy, halted, run, pc);
    end
    mem[0] = 9'b001001000; mem[1] = 9'd3; mem[2] = 9'b010001001; mem[3] = 9'b100000000;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      start = (c >= 3 && c <= 7);
      if (c == 6 || c == 8) begin
        checks++;
        if (pc !== 5'd2) begin fails++; $display("FAIL start_in_wait_c%0d: pc=%0d, want 2", c, pc); end
      end
      if (c == 9) begin
        checks++;
        if (pc !== 5'd3 || r[1] !== 9'd6) begin
          fails++; $display("FAIL start_ignored_result: pc=%0d r1=%0d, want 3 6", pc, r[1]);
        end
      end
    end
    checks++;
    if (halted !== 1'b1) begin fails++; $display("FAIL ign_halted: halted=%b, want 1", halted); end
    done_force = 1'b1;
    tick();
    tick();
    done_force = 1'b0;
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || pc !== 5'd3) begin
      fails++; $display("FAIL done_in_halted: halted=%b busy=%b pc=%0d, want 1 0 3", halted, busy, pc);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (halted !== 1'b0 || busy !== 1'b1 || pc !== 5'd0) begin
      fails++; $display("FAIL restart_halted: halted=%b busy=%b pc=%0d, want 0 1 0", halted, busy, pc);
    end
    tick();
    checks++;
    if (run !== 1'b1 || din !== 9'b001001000) begin
      fails++; $display("FAIL restart_issue: run=%b din=%b, want 1 001001000", run, din);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; done_force = 1'b0; proc_hang = 1'b0;
    test_reset();
    test_mvi();
    test_add_sub();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/prog_feeder.md
# prog_feeder

Instruction sequencer that sits directly upstream of the 9-bit bus processor. It fetches 9-bit program words from a synchronous-read program memory and presents them on the processor's DIN with a one-cycle Run pulse. It supplies the immediate word for mvi on the following cycle and waits for the processor's Done before fetching the next instruction. Opcodes the processor does not implement are decoded as HALT.

## Interface
- ADDR_W, 5, program memory address width; program counter wraps modulo 2^ADDR_W
- TIMEOUT, 3, maximum WAIT cycles without Done before Error
- Clock  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-high; the top level drives the processor's Resetn from ~Reset
- Start  in  1  begin execution at address 0; honoured only in IDLE or HALTED
- Done  in  1  processor Done, combinational from the processor
- MemData  in  9  program memory read data
- MemAddr  out  ADDR_W  program memory address (combinational)
- DIN  out  9  to processor DIN (combinational)
- Run  out  1  to processor Run (registered)
- PC  out  ADDR_W  address of the current instruction
- Busy  out  1  high in FETCH, ISSUE, IMM and WAIT
- Halted  out  1  HALT opcode reached
- Error  out  1  sticky; Done timeout

## Operation
- Memory contract: MemAddr is sampled at a rising edge, and MemData is valid for the whole following cycle.
- MemAddr = PC+1 (mod 2^ADDR_W) in ISSUE, and PC in every other state.
- DIN = MemData in ISSUE and IMM, and 9'b0 otherwise.
- Opcode field is MemData[8:6]:
  - 000 mv, 001 mvi, 010 add, 011 sub.
  - 100–111 are HALT and are never issued to the processor.
- States:
  - IDLE: Start -> PC<=0, go to FETCH.
  - FETCH: one cycle while memory reads PC. Always go to ISSUE.
  - ISSUE: Run=1, DIN = instruction.
    - If opcode is HALT: Run is forced to 0, go to HALTED; PC is unchanged.
    - If opcode is mvi: go to IMM.
    - Otherwise: go to WAIT with the timeout counter cleared.
  - IMM: DIN = immediate word at PC+1. On Done: PC<=PC+2, go to FETCH.
  - WAIT: on Done: PC<=PC+1, go to FETCH.
  - Timeout (IMM and WAIT): after TIMEOUT cycles in IMM/WAIT without Done, go to ERROR.
  - HALTED: Halted=1. Start -> PC<=0, Halted<=0, go to FETCH.
  - ERROR: Error=1, Run=0. Only Reset exits.
- Done is ignored outside IMM and WAIT.
- Start is ignored in FETCH, ISSUE, IMM, WAIT and ERROR.
- PC arithmetic is modulo 2^ADDR_W. An mvi at the last address takes its immediate from address 0, and PC then becomes 1.

## Timing
- Reset values: state IDLE, PC=0, Run=0, DIN=0, MemAddr=0, Busy=0, Halted=0, Error=0. All of these take effect immediately on Reset, including mid-instruction.
- Run is high for exactly one cycle per instruction (the ISSUE cycle), which coincides with processor T0. The processor latches IR at the end of ISSUE.
- Cycles per instruction, from FETCH entry to the next FETCH entry:
  - mv: 3 (Done in processor T1, the feeder's WAIT cycle 1).
  - mvi: 3 (Done in IMM).
  - add/sub: 5 (Done in processor T3, WAIT cycle 3).
- From a Start edge: FETCH is the next cycle, and the first Run is 2 cycles after Start.
- HALT: ISSUE for one cycle with Run=0, then Halted=1 and Busy=0 from the next cycle.
- Timeout: Error rises on the cycle after the TIMEOUT-th Done-less IMM/WAIT cycle. Busy drops on the same cycle.

## Test plan
- mvi with real processor:
  - Stimulus: memory[0]=9'b001000000, [1]=9'd5, [2]=9'b100000000; pulse Start.
  - Required: DIN=9'b001000000 with Run=1 in cycle 2; DIN=5 in cycle 3; processor R0=5; PC=2; Halted=1 in cycle 7; Run high in exactly one cycle.
- Add/sub sequence:
  - Program: mvi R1,3; mvi R2,4; add R1,R2; sub R1,R2; halt.
  - Required: R1=7 after add, R1=3 after sub; add and sub each take 5 cycles FETCH-to-FETCH.
- Address wrap with ADDR_W=2:
  - Stimulus: mvi R0 at address 3, immediate 9'd9 at address 0.
  - Required: MemAddr=0 during ISSUE, DIN=9 in IMM, PC=1 afterwards.
- Timeout:
  - Stimulus: stub processor holds Done=0 after an add.
  - Required: Error=1 on the 4th cycle after ISSUE, Busy=0, Run stays 0; Start has no effect until Reset.
- Reset mid-operation:
  - Stimulus: assert Reset during WAIT of an add.
  - Required: Run, DIN, PC and Busy are 0 in the same cycle. After release, Start re-fetches from address 0.
- Ignored events:
  - Start pulsed during IMM/WAIT: no PC change.
  - Done pulsed in IDLE or HALTED: no state change.
  - Start in HALTED restarts at address 0 with Halted cleared.
